// File: rtl/freq_ratio_select.sv
// freq_ratio_select: debounced up/down buttons with auto-repeat driving a saturating 8-bit divider ratio
module freq_ratio_select #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY = 64,
  parameter int REPEAT_PERIOD = 16,
  parameter logic [7:0] RATIO_INIT = 8'h05,
  parameter logic [7:0] RATIO_MIN = 8'h01,
  parameter logic [7:0] RATIO_MAX = 8'hFF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [7:0] ratio,
  output logic       ratio_changed
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int TMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW = $clog2(TMAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
  logic [1:0] raw, deb, step;
  logic up, dn;
  logic [7:0] ratio_nx;
  assign raw = {btn_down, btn_up};
  for (genvar i = 0; i < 2; i++) begin : g_btn
    logic [1:0] sync;
    logic [CW-1:0] cnt;
    logic [TW-1:0] timer, timer_nx;
    logic deb_q, stp;
    state_t state, state_nx;
    assign deb[i] = deb_q;
    assign step[i] = stp;
    always_ff @(posedge clock)
      if (reset) begin
        sync <= '0;
        cnt <= '0;
        deb_q <= 1'b0;
        state <= IDLE;
        timer <= '0;
      end else begin
        sync <= {sync[0], raw[i]};
        cnt <= (sync[1] == deb_q || cnt == CNT_LAST) ? '0 : cnt + CW'(1);
        if (sync[1] != deb_q && cnt == CNT_LAST) deb_q <= sync[1];
        state <= state_nx;
        timer <= timer_nx;
      end
    always_comb begin
      state_nx = state;
      timer_nx = timer;
      stp = 1'b0;
      if (!deb_q) state_nx = IDLE;
      else if (state == IDLE) begin
        stp = 1'b1;
        state_nx = HOLD;
        timer_nx = TW'(REPEAT_DELAY - 1);
      end else if (timer == '0) begin
        stp = 1'b1;
        state_nx = REPEAT;
        timer_nx = TW'(REPEAT_PERIOD - 1);
      end else timer_nx = timer - TW'(1);
    end
  end
  // Opposing steps cancel; holding both buttons freezes the ratio while timers keep running.
  always_comb begin
    up = step[0] & ~step[1] & ~&deb;
    dn = step[1] & ~step[0] & ~&deb;
    ratio_nx = up ? (ratio < RATIO_MAX ? ratio + 8'd1 : RATIO_MAX) :
               dn ? (ratio > RATIO_MIN ? ratio - 8'd1 : RATIO_MIN) : ratio;
  end
  always_ff @(posedge clock)
    if (reset) begin
      ratio <= RATIO_INIT;
      ratio_changed <= 1'b0;
    end else begin
      ratio <= ratio_nx;
      ratio_changed <= ratio_nx != ratio;
    end
endmodule
